// File: rtl/calc_sequencer.sv
// Calculator control sequencer: gathers decimal operands and the sign key,
// latches the operator, runs the ALU through a start/done handshake and
// supports operator chaining. Drives the signed display value and flags.
module calc_sequencer #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dig_strobe,
    input  logic             reset_strobe,
    input  logic             ex_strobe,
    input  logic             op_strobe,
    input  logic             sub_strobe,
    input  logic [3:0]       dig_code,
    input  logic [1:0]       op_code,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_error,
    output logic [WIDTH-1:0] display_value,
    output logic             busy,
    output logic             error
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        ENTER_A     = 3'd0,
        OP_WAIT     = 3'd1,
        ENTER_B     = 3'd2,
        EXEC        = 3'd3,
        SHOW_RESULT = 3'd4,
        ERROR       = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [1:0]       op_q, op_d, pend_q, pend_d;
    logic             chain_q, chain_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic             busy_q, busy_d, error_q, error_d;

    function automatic logic [WIDTH-1:0] signed_val(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    function automatic logic [WIDTH-1:0] push_digit(input logic [WIDTH-1:0] mag, input logic [3:0] d);
        return (mag * WIDTH'(10)) + WIDTH'(d);
    endfunction

    // Next-state logic for the sequencer and all registered outputs.
    always_comb begin
        // NOTE: every _d gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        cnt_d   = cnt_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        op_d    = op_q;
        pend_d  = pend_q;
        chain_d = chain_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        start_d = 1'b0;

        if (reset_strobe) begin
            state_d = ENTER_A;
            mag_a_d = '0;
            mag_b_d = '0;
            cnt_d   = '0;
            neg_a_d = 1'b0;
            neg_b_d = 1'b0;
            op_d    = '0;
            pend_d  = '0;
            chain_d = 1'b0;
            alu_a_d = '0;
            alu_b_d = '0;
        end else begin
            unique case (state_q)
                ENTER_A: begin
                    if (ex_strobe) begin
                        // equals has nothing to act on yet
                    end else if (op_strobe) begin
                        if (sub_strobe && cnt_q == '0) begin
                            neg_a_d = ~neg_a_q;
                        end else if (cnt_q != '0) begin
                            op_d    = op_code;
                            mag_b_d = '0;
                            neg_b_d = 1'b0;
                            cnt_d   = '0;
                            state_d = OP_WAIT;
                        end
                    end else if (dig_strobe && cnt_q < CW'(MAX_DIGITS)) begin
                        mag_a_d = push_digit(mag_a_q, dig_code);
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                OP_WAIT: begin
                    if (ex_strobe) begin
                        // no B operand yet
                    end else if (op_strobe) begin
                        if (sub_strobe) neg_b_d = ~neg_b_q;
                        else            op_d    = op_code;
                    end else if (dig_strobe) begin
                        mag_b_d = WIDTH'(dig_code);
                        cnt_d   = CW'(1);
                        state_d = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (ex_strobe || op_strobe) begin
                        chain_d = !ex_strobe;
                        if (!ex_strobe) pend_d = op_code;
                        alu_a_d = signed_val(mag_a_q, neg_a_q);
                        alu_b_d = signed_val(mag_b_q, neg_b_q);
                        start_d = 1'b1;
                        state_d = EXEC;
                    end else if (dig_strobe && cnt_q < CW'(MAX_DIGITS)) begin
                        mag_b_d = push_digit(mag_b_q, dig_code);
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                EXEC: begin
                    if (alu_done) begin
                        if (alu_error) begin
                            state_d = ERROR;
                        end else begin
                            mag_a_d = alu_result;
                            neg_a_d = 1'b0;
                            mag_b_d = '0;
                            neg_b_d = 1'b0;
                            cnt_d   = '0;
                            if (chain_q) begin
                                op_d    = pend_q;
                                state_d = OP_WAIT;
                            end else begin
                                state_d = SHOW_RESULT;
                            end
                        end
                    end
                end
                SHOW_RESULT: begin
                    if (ex_strobe) begin
                        // result already shown
                    end else if (op_strobe) begin
                        op_d    = op_code;
                        mag_b_d = '0;
                        neg_b_d = 1'b0;
                        cnt_d   = '0;
                        state_d = OP_WAIT;
                    end else if (dig_strobe) begin
                        mag_a_d = WIDTH'(dig_code);
                        neg_a_d = 1'b0;
                        cnt_d   = CW'(1);
                        state_d = ENTER_A;
                    end
                end
                ERROR: begin
                    // only the clear key leaves this state
                end
                default: state_d = ENTER_A;
            endcase
        end

        unique case (state_d)
            ENTER_A, OP_WAIT, SHOW_RESULT: disp_d = signed_val(mag_a_d, neg_a_d);
            ENTER_B, EXEC:                 disp_d = signed_val(mag_b_d, neg_b_d);
            default:                       disp_d = '0;
        endcase
        busy_d  = (state_d == EXEC);
        error_d = (state_d == ERROR);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= ENTER_A;
            mag_a_q <= '0;
            mag_b_q <= '0;
            cnt_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            op_q    <= '0;
            pend_q  <= '0;
            chain_q <= 1'b0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            start_q <= 1'b0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            cnt_q   <= cnt_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
            chain_q <= chain_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            start_q <= start_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = op_q;
    assign alu_start     = start_q;
    assign display_value = disp_q;
    assign busy          = busy_q;
    assign error         = error_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed calculator scenarios followed by random
// key sequences, all compared against a calculator model kept in the bench.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        dig_strobe, reset_strobe, ex_strobe, op_strobe, sub_strobe;
    logic [3:0]  dig_code;
    logic [1:0]  op_code;
    logic [15:0] alu_a, alu_b, alu_result, display_value;
    logic [1:0]  alu_op;
    logic        alu_start, alu_done, alu_error, busy, error;

    int total = 0;
    int bad   = 0;

    calc_sequencer #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clk(clk), .reset(reset),
        .dig_strobe(dig_strobe), .reset_strobe(reset_strobe), .ex_strobe(ex_strobe),
        .op_strobe(op_strobe), .sub_strobe(sub_strobe),
        .dig_code(dig_code), .op_code(op_code),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result), .alu_error(alu_error),
        .display_value(display_value), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // Calculator model: what a user of the calculator expects to see.
    typedef enum {M_A, M_OPW, M_B, M_EXEC, M_SHOW, M_ERR} mode_t;
    mode_t mode;
    int    a_mag, b_mag, ndig, op, pend;
    bit    a_neg, b_neg, chain;

    function automatic int a_val(); return a_neg ? -a_mag : a_mag; endfunction
    function automatic int b_val(); return b_neg ? -b_mag : b_mag; endfunction
    function automatic logic [15:0] w16(input int v); return v[15:0]; endfunction

    function automatic logic [15:0] exp_disp();
        if (mode == M_ERR) return 16'd0;
        if (mode == M_B || mode == M_EXEC) return w16(b_val());
        return w16(a_val());
    endfunction

    function automatic void m_clear();
        mode = M_A; a_mag = 0; b_mag = 0; ndig = 0; op = 0; pend = 0;
        a_neg = 0; b_neg = 0; chain = 0;
    endfunction

    function automatic void m_dig(input int d);
        case (mode)
            M_A:    if (ndig < 4) begin a_mag = a_mag * 10 + d; ndig++; end
            M_OPW:  begin b_mag = d; ndig = 1; mode = M_B; end
            M_B:    if (ndig < 4) begin b_mag = b_mag * 10 + d; ndig++; end
            M_SHOW: begin a_mag = d; a_neg = 0; ndig = 1; mode = M_A; end
            default: ;
        endcase
    endfunction

    function automatic void m_op(input int code);
        bit s = (code == 1);
        case (mode)
            M_A: begin
                if (s && ndig == 0) a_neg = !a_neg;
                else if (ndig > 0) begin op = code; b_mag = 0; b_neg = 0; ndig = 0; mode = M_OPW; end
            end
            M_OPW:  if (s) b_neg = !b_neg; else op = code;
            M_B:    begin chain = 1; pend = code; mode = M_EXEC; end
            M_SHOW: begin op = code; b_mag = 0; b_neg = 0; ndig = 0; mode = M_OPW; end
            default: ;
        endcase
    endfunction

    function automatic void m_ex();
        if (mode == M_B) begin chain = 0; mode = M_EXEC; end
    endfunction

    function automatic void m_done(input int res, input bit err);
        if (mode != M_EXEC) return;
        if (err) begin mode = M_ERR; return; end
        a_mag = res; a_neg = 0; b_mag = 0; b_neg = 0; ndig = 0;
        if (chain) begin op = pend; mode = M_OPW; end
        else mode = M_SHOW;
    endfunction

    // Ideal ALU: exact integer arithmetic, error when out of 16-bit range or /0.
    task automatic alu_model(output int res, output bit err);
        longint x = a_val();
        longint y = b_val();
        longint r = 0;
        err = 0;
        case (op)
            0: r = x + y;
            1: r = x - y;
            2: r = x * y;
            default: if (y == 0) err = 1; else r = x / y;
        endcase
        if (r > 32767 || r < -32768) err = 1;
        res = err ? 0 : int'(r);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_disp"}, {16'd0, display_value}, {16'd0, exp_disp()});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, mode == M_EXEC});
        chk({tag, "_err"},  {31'd0, error}, {31'd0, mode == M_ERR});
        chk({tag, "_op"},   {30'd0, alu_op}, op);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dig_strobe = 0; reset_strobe = 0; ex_strobe = 0; op_strobe = 0; sub_strobe = 0;
        dig_code = 0; op_code = 0;
    endtask

    task automatic key_dig(input int d);
        dig_strobe = 1; dig_code = 4'(d);
        tick(); clear_inputs();
        m_dig(d); check_outputs("dig");
    endtask

    task automatic key_op(input int code);
        op_strobe = 1; op_code = 2'(code); sub_strobe = (code == 1);
        tick(); clear_inputs();
        m_op(code); check_outputs("op");
    endtask

    task automatic key_ex();
        ex_strobe = 1;
        tick(); clear_inputs();
        m_ex(); check_outputs("ex");
    endtask

    task automatic key_clr();
        reset_strobe = 1;
        tick(); clear_inputs();
        m_clear(); check_outputs("clr");
        chk("clr_alu_a", {16'd0, alu_a}, 0);
        chk("clr_alu_b", {16'd0, alu_b}, 0);
    endtask

    // Completion pulse arriving while no operation is in flight.
    task automatic stale_done(input int res);
        alu_done = 1; alu_result = w16(res); alu_error = 1'($urandom_range(0, 1));
        tick();
        alu_done = 0; alu_error = 0;
        check_outputs("stale");
    endtask

    // Serve one ALU operation after lat extra cycles in EXEC.
    task automatic alu_run(input int lat);
        int res;
        bit err;
        int bc = 0;
        int sc = 0;
        logic [15:0] ea = w16(a_val());
        logic [15:0] eb = w16(b_val());
        alu_model(res, err);
        chk("launch_start", {31'd0, alu_start}, 1);
        for (int i = 0; i <= lat; i++) begin
            bc += int'(busy);
            sc += int'(alu_start);
            chk("hold_a", {16'd0, alu_a}, {16'd0, ea});
            chk("hold_b", {16'd0, alu_b}, {16'd0, eb});
            if (i == lat) begin
                alu_done = 1; alu_result = w16(res); alu_error = err;
            end
            tick();
            alu_done = 0; alu_error = 0;
        end
        chk("busy_cycles", bc, lat + 1);
        chk("start_pulses", sc, 1);
        m_done(res, err);
        check_outputs("done");
    endtask

    // Clear during EXEC after lat cycles, then a late completion.
    task automatic alu_abort(input int lat);
        for (int i = 0; i < lat; i++) tick();
        key_clr();
        stale_done(99);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        alu_done = 0; alu_error = 0; alu_result = 0;
        reset = 1;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset_start", {31'd0, alu_start}, 0);
        chk("reset_alu_a", {16'd0, alu_a}, 0);
        reset = 0;

        // 12 + 34 = 46 with a 3-cycle ALU latency
        key_dig(1); key_dig(2); key_op(0); key_dig(3); key_dig(4); key_ex();
        chk("t1_alu_a", {16'd0, alu_a}, 12);
        chk("t1_alu_b", {16'd0, alu_b}, 34);
        alu_run(3);
        chk("t1_disp", {16'd0, display_value}, 46);

        // fifth digit is dropped
        key_clr();
        key_dig(1); key_dig(2); key_dig(3); key_dig(4); key_dig(5);
        chk("t2_disp", {16'd0, display_value}, 1234);

        // -7 * -3
        key_clr();
        key_op(1); key_dig(7); key_op(2); key_op(1); key_dig(3); key_ex();
        chk("t3_alu_a", {16'd0, alu_a}, {16'd0, 16'hFFF9});
        chk("t3_alu_b", {16'd0, alu_b}, {16'd0, 16'hFFFD});
        chk("t3_alu_op", {30'd0, alu_op}, 2);
        alu_run(1);

        // chaining: 5 + 3 - 2
        key_clr();
        key_dig(5); key_op(0); key_dig(3); key_op(1);
        alu_run(2);
        chk("t4_disp", {16'd0, display_value}, 8);
        chk("t4_op", {30'd0, alu_op}, 1);
        key_dig(2); key_ex();
        chk("t4_alu_a", {16'd0, alu_a}, 8);
        chk("t4_alu_b", {16'd0, alu_b}, 2);
        alu_run(0);

        // divide by zero, then keys ignored until clear
        key_clr();
        key_dig(9); key_op(3); key_dig(0); key_ex();
        alu_run(2);
        chk("t5_err", {31'd0, error}, 1);
        key_dig(4); key_ex(); key_op(0);
        stale_done(5);
        key_clr();
        key_dig(6);

        // clear mid-EXEC, then a late completion
        key_clr();
        key_dig(4); key_op(2); key_dig(2); key_ex();
        alu_abort(2);
        key_dig(3);

        // asynchronous reset pin mid-entry
        key_dig(7);
        #3 reset = 1;
        #1;
        m_clear();
        chk("arst_disp", {16'd0, display_value}, 0);
        chk("arst_alu_a", {16'd0, alu_a}, 0);
        chk("arst_alu_b", {16'd0, alu_b}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1 reset = 0;
        check_outputs("arst_rel");

        // random key sequences
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(0, 99);
            if (mode == M_ERR && r < 40) key_clr();
            else if (r < 50) key_dig($urandom_range(0, 9));
            else if (r < 78) key_op($urandom_range(0, 3));
            else if (r < 90) key_ex();
            else if (r < 94) key_clr();
            else stale_done($urandom_range(0, 999));
            if (mode == M_EXEC) begin
                if ($urandom_range(0, 19) == 0) alu_abort($urandom_range(0, 3));
                else alu_run($urandom_range(0, 4));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Central control FSM of the calculator, sitting between the keypad strobe decoder and the arithmetic unit. It accumulates decimal operand entry and handles the sign key. It latches the operator, launches the ALU with a start/done handshake, and supports operator chaining. It drives the signed value shown on the display and an error flag.

Parameters:
WIDTH, 16, two's-complement width of operands, result and display value
MAX_DIGITS, 4, maximum decimal digits per operand; 10^MAX_DIGITS-1 must fit in WIDTH-1 bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
dig_strobe  input  1  one-cycle pulse: digit key
reset_strobe  input  1  one-cycle pulse: clear key
ex_strobe  input  1  one-cycle pulse: equals key
op_strobe  input  1  one-cycle pulse: any operator key
sub_strobe  input  1  one-cycle pulse: minus key; always coincident with op_strobe
dig_code  input  4  digit value 0-9, valid with dig_strobe
op_code  input  2  operator code valid with op_strobe: 0 add, 1 sub, 2 mul, 3 div
alu_a  output  WIDTH  signed operand A, held stable from alu_start until alu_done
alu_b  output  WIDTH  signed operand B, held stable from alu_start until alu_done
alu_op  output  2  latched operator
alu_start  output  1  one-cycle launch pulse
alu_done  input  1  one-cycle completion pulse from ALU
alu_result  input  WIDTH  signed result, valid with alu_done
alu_error  input  1  overflow or divide-by-zero, valid with alu_done
display_value  output  WIDTH  signed value to display
busy  output  1  high while in EXEC
error  output  1  high while in ERROR

Behaviour:
- Reset, asynchronous: state ENTER_A. acc_a, acc_b, digit count, neg_a, neg_b, op, chain and pending_op are all 0. All outputs are 0.
- Operand value = neg ? -mag : mag. Digit entry: mag <= mag*10 + dig_code, count++, only when count < MAX_DIGITS. Extra digits are silently dropped.
- reset_strobe: highest priority. From any state it performs the reset clear on the next edge, including mid-EXEC and from ERROR.
- Simultaneous strobes other than op/sub are not produced upstream. If they do occur, priority is reset > ex > op > dig.
- ENTER_A:
  - dig: accumulate into A.
  - sub_strobe with count==0: toggles neg_a; it is not treated as an operator.
  - op with count>0: latch op, clear B, go to OP_WAIT.
  - op with count==0, non-sub: ignored. ex: ignored.
- OP_WAIT:
  - dig: first digit of B, go to ENTER_B.
  - sub: toggles neg_b.
  - non-sub op: replaces latched op.
  - ex: ignored.
- ENTER_B:
  - dig: accumulate into B.
  - ex: chain=0, go to EXEC.
  - op: chain=1, pending_op=op_code, go to EXEC.
- EXEC:
  - alu_start is high for exactly the first cycle in EXEC. Operands and op are held.
  - Waits any number of cycles for alu_done.
  - alu_done with alu_error: go to ERROR.
  - alu_done without error: A <= alu_result, B cleared.
  - Then chain=1: op <= pending_op, go to OP_WAIT. Chain=0: go to SHOW_RESULT.
  - Key strobes other than reset are ignored in EXEC.
- SHOW_RESULT:
  - dig: A cleared and starts a fresh entry with that digit, neg_a=0, go to ENTER_A.
  - op (sub is an operator here): A retained, go to OP_WAIT.
  - ex: ignored.
- ERROR: all keys except reset_strobe are ignored.
- alu_done outside EXEC (stale after an abort): ignored.
- display_value:
  - ENTER_A, OP_WAIT, SHOW_RESULT: signed A.
  - ENTER_B, EXEC: signed B.
  - ERROR: 0.
  - Registered; updates the cycle after the causing strobe.

Test Plan:
- Keys 1,2,+,3,4,= then alu_done with result 46 after 3 cycles -> alu_a=12, alu_b=34, alu_op=0, a single alu_start pulse, busy high for 4 cycles, display_value=46.
- Keys 1,2,3,4,5 -> display_value=1234; the fifth digit is dropped.
- Keys -,7,*,-,3,= -> alu_a=-7, alu_b=-3, alu_op=2.
- Keys 5,+,3,- then done with result 8 -> state OP_WAIT, display_value=8, alu_op=1. Then 2,= -> alu_a=8, alu_b=2.
- Keys 9,/,0,= then done with alu_error=1 -> error=1, display_value=0. Digits and ex are ignored; reset_strobe -> error=0, state ENTER_A.
- reset_strobe during EXEC, then a late alu_done with result 99 -> busy=0, display_value=0, no state change.
- reset pin asserted mid-entry -> all outputs 0 immediately, without waiting for a clock edge.
